pattern_counter: RTL
====================

PATTERN_COUNTER -- requirements
Module: pattern_counter

Interface
REQ-001 The module SHALL have a parameter PAT_W, default 5, giving the pattern width in bits; legal range is 1..8.
REQ-002 The module SHALL have a parameter NBYTES, default 32, giving the number of message bytes per job; legal range is 1..255.
REQ-003 The module SHALL have a parameter CNT_W, default 8, giving the width of each result counter.
REQ-004 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: single-cycle pulse that begins a job.
REQ-007 Port pat, input, PAT_W bits: the search pattern, sampled on start.
REQ-008 Port in_valid, input, 1 bit: in_data holds a message byte.
REQ-009 Port in_data, input, 8 bits: message byte; bit 7 is first in the stream.
REQ-010 Port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-011 Port halt, output, 1 bit: the job is complete and results are valid.
REQ-012 Port ctb, output, CNT_W bits: total in-byte pattern occurrences.
REQ-013 Port cto, output, CNT_W bits: number of bytes containing at least one occurrence.
REQ-014 Port cts, output, CNT_W bits: occurrences in the whole concatenated bit string, including those spanning byte boundaries.

Function
REQ-015 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-016 start in IDLE or DONE SHALL latch pat, clear ctb/cto/cts and the byte counter, deassert halt, and enter RUN on the next edge.
REQ-017 start in RUN SHALL abort the current job and restart it with the same actions as REQ-016; any byte offered in that cycle SHALL be discarded.
REQ-018 in_ready SHALL be 1 only in RUN; a byte is accepted on an edge where in_valid and in_ready are both 1.
REQ-019 in_valid gaps SHALL stall the job without affecting results.
REQ-020 For each accepted byte, windows SHALL be the in-byte bit slices [k+PAT_W-1:k], for k = 0..8-PAT_W.
  - ctb SHALL increase by the number of windows equal to the latched pattern.
  - cto SHALL increase by 1 if any window matches.
REQ-021 For cts, the block SHALL keep the last PAT_W-1 stream bits from previous bytes.
  - The first byte of a job SHALL contribute windows lying wholly within it (9-PAT_W windows).
  - Each later byte SHALL contribute the 8 windows ending within it.
  - A job SHALL therefore check NBYTES*8-PAT_W+1 windows in total.
REQ-022 All updates for a byte SHALL complete in its accept cycle, giving single-cycle throughput and no internal backpressure.
REQ-023 Each counter SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-024 After the NBYTES-th byte is accepted, the block SHALL enter DONE on that edge, and halt SHALL be 1 in the following cycle with final counts.
REQ-025 In DONE, halt and the counts SHALL hold until the next start.
REQ-026 In IDLE and DONE, in_valid SHALL be ignored.
REQ-027 The counts SHALL be registered outputs, readable in any state.

Reset
REQ-028 While reset_n is 0, the block SHALL be in IDLE with halt=0, in_ready=0, ctb=cto=cts=0, the byte counter cleared, and the carry bits cleared.
REQ-029 Reset asserted mid-job SHALL discard the job; after reset release, only a new start SHALL begin work.

Verification
REQ-030 Reset check: assert reset_n=0 during RUN after 10 bytes -> the next cycle shows IDLE, halt=0, in_ready=0 and all counts 0; then start -> a fresh, correct job.
REQ-031 Zero-pattern check (default parameters): pat=5'b00000 and 32 bytes of 0x00 -> ctb=128, cto=32, cts=252, halt=1.
REQ-032 Cross-byte check: pat=5'b11111 and bytes alternating 0xF8,0x07 starting with 0xF8 -> ctb=16, cto=16, cts=61.
REQ-033 Throttling check: repeat REQ-031 with in_valid randomly low about 50% of cycles -> identical results, with halt 1 cycle after the 32nd accept.
REQ-034 Saturation check: CNT_W=4, pat=0 and all-zero bytes -> ctb=cto=cts=15.
REQ-035 Restart check: start pulsed after 5 bytes of a job -> counts cleared, and the final result reflects only the following 32 bytes.

Source files
------------

// File: rtl/pattern_counter_if.sv
// Job handshake, byte stream and result bus between a controller and pattern_counter.
interface pattern_counter_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);
  logic             start;
  logic [PAT_W-1:0] pat;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             halt;
  logic [CNT_W-1:0] ctb;
  logic [CNT_W-1:0] cto;
  logic [CNT_W-1:0] cts;

  modport master (
    output start, pat, in_valid, in_data,
    input  in_ready, halt, ctb, cto, cts
  );

  modport slave (
    input  start, pat, in_valid, in_data,
    output in_ready, halt, ctb, cto, cts
  );
endinterface

// File: rtl/pattern_counter.sv
// Counts pattern occurrences in a byte stream: within bytes (ctb), bytes with any hit (cto)
// and across the whole concatenated bit stream (cts). One byte per cycle, saturating counts.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting message bytes
// DONE  | job complete, halt and counts held until next start
module pattern_counter #(
  parameter int PAT_W  = 5,
  parameter int NBYTES = 32,
  parameter int CNT_W  = 8
) (
  input logic              CLK,
  input logic              reset_n,
  pattern_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Bit j set when the window ending at in-byte bit j lies wholly inside the byte.
  function automatic logic [7:0] in_mask_f();
    logic [7:0] m;
    m = '0;
    for (int j = 0; j < 8; j++) m[j] = (j <= 8 - PAT_W);
    return m;
  endfunction

  localparam logic [7:0] IN_MASK = in_mask_f();

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] inc);
    logic [CNT_W+3:0] s;
    logic [CNT_W+3:0] top;
    s   = {4'b0000, a} + {{CNT_W{1'b0}}, inc};
    top = {4'b0000, {CNT_W{1'b1}}};
    if (s > top) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [6:0]       carry_q, carry_d;
  logic [CNT_W-1:0] ctb_q, ctb_d;
  logic [CNT_W-1:0] cto_q, cto_d;
  logic [CNT_W-1:0] cts_q, cts_d;

  logic [14:0] stream;
  logic [7:0]  hit;
  logic [7:0]  in_hit;
  logic [7:0]  span_hit;
  logic        accept;

  // Previous stream bits sit above the new byte, so bit 7 of in_data follows carry bit 0.
  assign stream = {carry_q, bus.in_data};
  assign accept = (state_q == RUN) && bus.in_valid;

  always_comb begin
    hit = '0;
    for (int j = 0; j < 8; j++) hit[j] = (PAT_W'(stream >> j) == pat_q);
  end

  assign in_hit   = hit & IN_MASK;
  assign span_hit = (byte_cnt_q == 8'd0) ? in_hit : hit;

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    byte_cnt_d = byte_cnt_q;
    carry_d    = carry_q;
    ctb_d      = ctb_q;
    cto_d      = cto_q;
    cts_d      = cts_q;
    if (bus.start) begin
      state_d    = RUN;
      pat_d      = bus.pat;
      byte_cnt_d = '0;
      carry_d    = '0;
      ctb_d      = '0;
      cto_d      = '0;
      cts_d      = '0;
    end else if (accept) begin
      byte_cnt_d = byte_cnt_q + 8'd1;
      carry_d    = bus.in_data[6:0];
      ctb_d      = sat_add(ctb_q, popcnt8(in_hit));
      cto_d      = sat_add(cto_q, {3'b000, |in_hit});
      cts_d      = sat_add(cts_q, popcnt8(span_hit));
      if (byte_cnt_q == 8'(NBYTES - 1)) state_d = DONE;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      byte_cnt_q <= '0;
      carry_q    <= '0;
      ctb_q      <= '0;
      cto_q      <= '0;
      cts_q      <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      byte_cnt_q <= byte_cnt_d;
      carry_q    <= carry_d;
      ctb_q      <= ctb_d;
      cto_q      <= cto_d;
      cts_q      <= cts_d;
    end
  end

  assign bus.in_ready = (state_q == RUN);
  assign bus.halt     = (state_q == DONE);
  assign bus.ctb      = ctb_q;
  assign bus.cto      = cto_q;
  assign bus.cts      = cts_q;

endmodule
